// File: rtl/dpram_arb_if.sv
// Bundle of both requester ports plus the shared single-port RAM port.
// The arbiter sits on the slave modport; requesters and the RAM drive the master side.
interface dpram_arb_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              req0, req1;
    logic              we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0, gnt1;
    logic              rvalid0, rvalid1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic              ram_we;
    logic [DATA_W-1:0] ram_dout;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_dout,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, ram_addr, ram_din, ram_we
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_dout,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, ram_addr, ram_din, ram_we
    );
endinterface

// File: rtl/dpram_arb.sv
// Two-requester arbiter for one single-port synchronous RAM with a burst-limited sticky grant.
// Define DPRAM_ARB_STATS_EN to add saturating per-requester accepted-transaction counters gcnt0/gcnt1.
module dpram_arb #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    dpram_arb_if.slave  bus
`ifdef DPRAM_ARB_STATS_EN
    ,
    output logic [15:0] gcnt0,
    output logic [15:0] gcnt1
`endif
);

    typedef enum logic [1:0] {OWN_NONE, OWN0, OWN1} owner_t;

    localparam logic [3:0] MAX_B = 4'(MAX_BURST);

    owner_t     owner, owner_nxt;
    logic       last, last_nxt;
    logic [3:0] burst_cnt, burst_nxt;
    logic       gnt0, gnt1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner     <= OWN_NONE;
            last      <= 1'b1;
            burst_cnt <= 4'd0;
        end else begin
            owner     <= owner_nxt;
            last      <= last_nxt;
            burst_cnt <= burst_nxt;
        end
    end

    // A repeat grant to the current owner extends its burst, saturating at MAX_B.
    always_comb begin
        owner_nxt = OWN_NONE;
        last_nxt  = last;
        burst_nxt = 4'd0;
        if (gnt0) begin
            owner_nxt = OWN0;
            if (owner == OWN0) begin
                burst_nxt = (burst_cnt >= MAX_B) ? MAX_B : burst_cnt + 4'd1;
            end else begin
                burst_nxt = 4'd1;
                last_nxt  = 1'b0;
            end
        end else if (gnt1) begin
            owner_nxt = OWN1;
            if (owner == OWN1) begin
                burst_nxt = (burst_cnt >= MAX_B) ? MAX_B : burst_cnt + 4'd1;
            end else begin
                burst_nxt = 4'd1;
                last_nxt  = 1'b1;
            end
        end
    end

    always_comb begin
        gnt0         = 1'b0;
        gnt1         = 1'b0;
        bus.ram_we   = 1'b0;
        bus.ram_addr = {ADDR_W{1'b0}};
        bus.ram_din  = {DATA_W{1'b0}};
        if (bus.req0 && bus.req1) begin
            if (owner == OWN0 && burst_cnt < MAX_B) begin
                gnt0 = 1'b1;
            end else if (owner == OWN1 && burst_cnt < MAX_B) begin
                gnt1 = 1'b1;
            end else if (last) begin
                gnt0 = 1'b1;
            end else begin
                gnt1 = 1'b1;
            end
        end else begin
            gnt0 = bus.req0;
            gnt1 = bus.req1;
        end
        if (gnt0) begin
            bus.ram_we   = bus.we0;
            bus.ram_addr = bus.addr0;
            bus.ram_din  = bus.wdata0;
        end else if (gnt1) begin
            bus.ram_we   = bus.we1;
            bus.ram_addr = bus.addr1;
            bus.ram_din  = bus.wdata1;
        end
    end

    assign bus.gnt0 = gnt0;
    assign bus.gnt1 = gnt1;

    // The RAM answers one cycle after the read was accepted; rvalid tracks that latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rvalid0 <= 1'b0;
            bus.rvalid1 <= 1'b0;
        end else begin
            bus.rvalid0 <= gnt0 & ~bus.we0;
            bus.rvalid1 <= gnt1 & ~bus.we1;
        end
    end

    assign bus.rdata0 = bus.ram_dout;
    assign bus.rdata1 = bus.ram_dout;

`ifdef DPRAM_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gcnt0 <= 16'd0;
            gcnt1 <= 16'd0;
        end else begin
            if (gnt0 && gcnt0 != 16'hFFFF) gcnt0 <= gcnt0 + 16'd1;
            if (gnt1 && gcnt1 != 16'hFFFF) gcnt1 <= gcnt1 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dpram_arb.sv
// Self-checking bench for dpram_arb: hand-written grant expectations, a behavioural RAM,
// and a read scoreboard. Define DPRAM_ARB_STATS_EN to also check the stats counters.
module tb_dpram_arb;

    typedef struct {
        logic       who;
        logic [7:0] data;
    } rd_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   testCount = 0;
    int   failCount = 0;
    rd_t  scoreboard[$];
    logic [7:0] mem    [256];
    logic [7:0] expMem [256];

`ifdef DPRAM_ARB_STATS_EN
    logic [15:0] gcnt0, gcnt1;
`endif

    always #5 clk = ~clk;

    dpram_arb_if #(.ADDR_W(8), .DATA_W(8)) bus();

    dpram_arb #(.ADDR_W(8), .DATA_W(8), .MAX_BURST(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef DPRAM_ARB_STATS_EN
        ,
        .gcnt0 (gcnt0),
        .gcnt1 (gcnt1)
`endif
    );

    // Single-port RAM with one-cycle synchronous read, read-before-write.
    always @(posedge clk) begin
        bus.ram_dout <= mem[bus.ram_addr];
        if (bus.ram_we) mem[bus.ram_addr] = bus.ram_din;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic checkRvalid();
        rd_t e;
        if (scoreboard.size() > 0) begin
            e = scoreboard.pop_front();
            checkOutput("rvalid0", 32'(bus.rvalid0), 32'(e.who == 1'b0));
            checkOutput("rvalid1", 32'(bus.rvalid1), 32'(e.who == 1'b1));
            checkOutput("rdata", 32'(e.who ? bus.rdata1 : bus.rdata0), 32'(e.data));
        end else begin
            checkOutput("rvalid0_idle", 32'(bus.rvalid0), 32'd0);
            checkOutput("rvalid1_idle", 32'(bus.rvalid1), 32'd0);
        end
    endtask

    task automatic driveIdle();
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = 8'h00; bus.wdata0 = 8'h00;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = 8'h00; bus.wdata1 = 8'h00;
    endtask

    // One clock cycle: drive both requesters, check grant and RAM port mid-cycle, log reads.
    task automatic applyStimulus(input logic r0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                                 input logic r1, input logic w1, input logic [7:0] a1, input logic [7:0] d1,
                                 input int expG);
        logic       eWe;
        logic [7:0] eAddr, eDin;
        bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
        bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
        @(negedge clk);
        checkRvalid();
        checkOutput("gnt0", 32'(bus.gnt0), 32'(expG == 1));
        checkOutput("gnt1", 32'(bus.gnt1), 32'(expG == 2));
        eWe = 1'b0; eAddr = 8'h00; eDin = 8'h00;
        if (expG == 1) begin
            eWe = w0; eAddr = a0; eDin = d0;
        end else if (expG == 2) begin
            eWe = w1; eAddr = a1; eDin = d1;
        end
        checkOutput("ram_we", 32'(bus.ram_we), 32'(eWe));
        checkOutput("ram_addr", 32'(bus.ram_addr), 32'(eAddr));
        checkOutput("ram_din", 32'(bus.ram_din), 32'(eDin));
        if (expG != 0) begin
            if (eWe) expMem[eAddr] = eDin;
            else scoreboard.push_back('{who: (expG == 2), data: expMem[eAddr]});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        driveIdle();
        scoreboard.delete();
        @(negedge clk);
        checkOutput("rst_rvalid0", 32'(bus.rvalid0), 32'd0);
        checkOutput("rst_rvalid1", 32'(bus.rvalid1), 32'd0);
        checkOutput("rst_ram_we", 32'(bus.ram_we), 32'd0);
        bus.req0 = 1'b1; bus.addr0 = 8'h77;
        #1;
        checkOutput("rst_gnt0_comb", 32'(bus.gnt0), 32'd1);
        checkOutput("rst_ram_addr", 32'(bus.ram_addr), 32'h77);
        bus.req0 = 1'b0; bus.addr0 = 8'h00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int expTie[10];
        int sel;
        logic w;
        logic [7:0] a, d;
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 8'(i) ^ 8'h5A;
            expMem[i] = 8'(i) ^ 8'h5A;
        end
        driveIdle();
        #1;
        doReset();

        // Write then read back through requester 0.
        applyStimulus(1, 1, 8'h01, 8'hA0, 0, 0, 8'h00, 8'h00, 1);
        applyStimulus(1, 0, 8'h01, 8'h00, 0, 0, 8'h00, 8'h00, 1);
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);

        // Tie from reset: four to 0, four to 1, then back to 0.
        doReset();
        expTie = '{1, 1, 1, 1, 2, 2, 2, 2, 1, 1};
        for (int i = 0; i < 10; i++)
            applyStimulus(1, 0, 8'(8'h10 + i), 8'h00, 1, 0, 8'(8'h20 + i), 8'h00, expTie[i]);
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);

        // Lone requester 1 is never cut off; its saturated burst hands the next tie to 0.
        for (int i = 0; i < 8; i++)
            applyStimulus(0, 0, 8'h00, 8'h00, 1, 0, 8'(8'h30 + i), 8'h00, 2);
        applyStimulus(1, 0, 8'h40, 8'h00, 1, 0, 8'h41, 8'h00, 1);
        applyStimulus(1, 0, 8'h42, 8'h00, 1, 0, 8'h43, 8'h00, 1);
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);

        // Port sharing: 0 writes, 1 reads the same word next cycle.
        applyStimulus(1, 1, 8'h03, 8'hC0, 0, 0, 8'h00, 8'h00, 1);
        applyStimulus(0, 0, 8'h00, 8'h00, 1, 0, 8'h03, 8'h00, 2);
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);

        // Reset in the middle of a burst drops the pending rvalid and restarts the burst.
        doReset();
        applyStimulus(1, 0, 8'h50, 8'h00, 1, 0, 8'h51, 8'h00, 1);
        applyStimulus(1, 0, 8'h52, 8'h00, 1, 0, 8'h53, 8'h00, 1);
        rst_n = 1'b0;
        scoreboard.delete();
        #1;
        checkOutput("midrst_rvalid0", 32'(bus.rvalid0), 32'd0);
        @(negedge clk);
        checkOutput("midrst_gnt0", 32'(bus.gnt0), 32'd1);
        checkOutput("midrst_gnt1", 32'(bus.gnt1), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        expTie = '{1, 1, 1, 1, 2, 0, 0, 0, 0, 0};
        for (int i = 0; i < 5; i++)
            applyStimulus(1, 0, 8'(8'h60 + i), 8'h00, 1, 0, 8'(8'h70 + i), 8'h00, expTie[i]);
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);

        // Random lone-requester traffic over a small address window.
        for (int i = 0; i < 30; i++) begin
            sel = int'($urandom_range(0, 2));
            w = 1'($urandom_range(0, 1));
            a = 8'($urandom_range(0, 15));
            d = 8'($urandom);
            applyStimulus(sel == 1, w, a, d, sel == 2, w, a, d, sel);
        end
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);

`ifdef DPRAM_ARB_STATS_EN
        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(1, 1, 8'(8'h80 + i), 8'(i), 0, 0, 8'h00, 8'h00, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 8'h00, 8'h00, 1, 1, 8'(8'h90 + i), 8'(i), 2);
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
        checkOutput("gcnt0", 32'(gcnt0), 32'd5);
        checkOutput("gcnt1", 32'(gcnt1), 32'd3);
        bus.req0 = 1'b1; bus.we0 = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        driveIdle();
        @(negedge clk);
        checkOutput("gcnt0_sat", 32'(gcnt0), 32'h0000FFFF);
        checkOutput("gcnt1_hold", 32'(gcnt1), 32'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
